nibble_serial_subtractor: RTL and testbench



---
 rtl/alu_pkg.sv | 11 +
 rtl/nibble_serial_subtractor_if.sv | 29 ++
 rtl/four_bit_subtractor.sv | 15 +
 rtl/nibble_serial_subtractor.sv | 117 +++++++++++
 tb/tb_nibble_serial_subtractor.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU datapath constants and the serial subtractor state type.
package alu_pkg;
  localparam int ALU_WIDTH  = 32;
  localparam int ALU_NIBBLE = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;
endpackage

// File: rtl/nibble_serial_subtractor_if.sv
// Request/result bundle of the nibble-serial subtractor.
// Handshake: a transfer happens on a rising edge where valid and ready are both high;
// the producer holds valid (and data) until it sees ready, and ready may not wait on valid.
interface nibble_serial_subtractor_if
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             done_valid;
  logic             done_ready;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             overflow;
  logic             zero;

  modport master (
    output start_valid, a, b, done_ready,
    input  start_ready, done_valid, diff, borrow, overflow, zero
  );

  modport slave (
    input  start_valid, a, b, done_ready,
    output start_ready, done_valid, diff, borrow, overflow, zero
  );
endinterface

// File: rtl/four_bit_subtractor.sv
// Combinational 4-bit subtract with borrow-in/borrow-out: d = a - b - bi.
module four_bit_subtractor (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       bi,
  output logic [3:0] d,
  output logic       bo
);
  logic [4:0] wide;

  // Bit 4 of the 5-bit difference is set exactly when a < b + bi.
  assign wide = {1'b0, a} - {1'b0, b} - {4'b0000, bi};
  assign d    = wide[3:0];
  assign bo   = wide[4];
endmodule

// File: rtl/nibble_serial_subtractor.sv
// 32-bit a - b computed one nibble per clock, LSB nibble first, through a single
// time-multiplexed 4-bit subtractor with a registered borrow chain.
module nibble_serial_subtractor
  import alu_pkg::*;
#(
  parameter int WIDTH  = ALU_WIDTH,
  parameter int NIBBLE = ALU_NIBBLE
) (
  input  logic                               clk,
  input  logic                               reset,
  nibble_serial_subtractor_if.slave          bus,
  output sub_state_t                         state_dbg,
  output logic [$clog2(WIDTH/NIBBLE)-1:0]    count_dbg
);
  localparam int NSTEPS = WIDTH / NIBBLE;
  localparam int CW     = $clog2(NSTEPS);
  localparam logic [CW-1:0] LAST = CW'(NSTEPS - 1);

  sub_state_t       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             chain_q, chain_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [NIBBLE-1:0] a_nib, b_nib, nib_d;
  logic              nib_bo;

  assign a_nib = a_q[int'(count_q)*NIBBLE +: NIBBLE];
  assign b_nib = b_q[int'(count_q)*NIBBLE +: NIBBLE];

  four_bit_subtractor u_sub (
    .a  (a_nib),
    .b  (b_nib),
    .bi (chain_q),
    .d  (nib_d),
    .bo (nib_bo)
  );

  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    a_d             = a_q;
    b_d             = b_q;
    chain_d         = chain_q;
    diff_d          = diff_q;
    borrow_d        = borrow_q;
    ovf_d           = ovf_q;
    zero_d          = zero_q;
    bus.start_ready = 1'b0;
    bus.done_valid  = 1'b0;
    case (state_q)
      IDLE: begin
        bus.start_ready = 1'b1;
        if (bus.start_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          chain_d = 1'b0;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        diff_d[int'(count_q)*NIBBLE +: NIBBLE] = nib_d;
        chain_d = nib_bo;
        if (count_q == LAST) begin
          // Flags are committed only once the top nibble is known.
          borrow_d = nib_bo;
          ovf_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (nib_d[NIBBLE-1] != a_q[WIDTH-1]);
          zero_d   = ~|diff_d;
          count_d  = '0;
          state_d  = DONE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      DONE: begin
        bus.done_valid = 1'b1;
        if (bus.done_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      a_q      <= '0;
      b_q      <= '0;
      chain_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      a_q      <= a_d;
      b_q      <= b_d;
      chain_q  <= chain_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.diff     = diff_q;
  assign bus.borrow   = borrow_q;
  assign bus.overflow = ovf_q;
  assign bus.zero     = zero_q;
  assign state_dbg    = state_q;
  assign count_dbg    = count_q;
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Randomized bench for nibble_serial_subtractor against a plain-arithmetic reference model.
module tb_nibble_serial_subtractor;
  import alu_pkg::*;

  localparam int W = ALU_WIDTH;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic       clk = 1'b0;
  logic       reset;
  sub_state_t state_dbg;
  logic [2:0] count_dbg;

  nibble_serial_subtractor_if #(.WIDTH(W)) bus ();

  nibble_serial_subtractor #(.WIDTH(W), .NIBBLE(ALU_NIBBLE)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg),
    .count_dbg (count_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  // Expected results, {borrow, overflow, zero, diff}
  logic [W+2:0] exp_q[$];
  logic [W-1:0] corners[5];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [W+2:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    longint ua, ub, sa, sb, ud, sd;
    logic [W-1:0] d;
    logic bo, ov, z;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ud = ua - ub;
    sd = sa - sb;
    d  = ud[W-1:0];
    bo = (ua < ub);
    ov = (sd > SMAX) || (sd < SMIN);
    z  = (d == '0);
    return {bo, ov, z, d};
  endfunction

  task automatic check_result(input string tag, input logic [W+2:0] e);
    check({tag, "_diff"},     bus.diff,     e[W-1:0]);
    check({tag, "_borrow"},   bus.borrow,   e[W+2]);
    check({tag, "_overflow"}, bus.overflow, e[W+1]);
    check({tag, "_zero"},     bus.zero,     e[W]);
  endtask

  task automatic wait_idle();
    int waited = 0;
    while (bus.start_ready !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("start_ready_wait", bus.start_ready, 1);
  endtask

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b);
    wait_idle();
    bus.start_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    @(posedge clk); #1;
    bus.start_valid = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    logic [W+2:0] e;
    accept(a, b);
    exp_q.push_back(model(a, b));
    check("start_ready_in_run", bus.start_ready, 0);
    repeat (7) begin
      @(posedge clk); #1;
      bus.a = $urandom;
      bus.b = $urandom;
    end
    check("done_valid_early", bus.done_valid, 0);
    @(posedge clk); #1;
    check("done_valid_latency", bus.done_valid, 1);
    e = exp_q.pop_front();
    check_result("result", e);
    for (int i = 0; i < hold; i++) begin
      bus.start_valid = 1'($urandom_range(0, 1));
      bus.a = $urandom;
      bus.b = $urandom;
      @(posedge clk); #1;
      check("held_done_valid", bus.done_valid, 1);
      check("held_start_ready", bus.start_ready, 0);
      check_result("held", e);
    end
    bus.start_valid = 1'b0;
    bus.done_ready  = 1'b1;
    @(posedge clk); #1;
    bus.done_ready = 1'b0;
    check("done_valid_after_ack", bus.done_valid, 0);
    check("start_ready_after_ack", bus.start_ready, 1);
    @(posedge clk); #1;
    check_result("idle_hold", e);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},       state_dbg,        IDLE);
    check({tag, "_count"},       count_dbg,        0);
    check({tag, "_start_ready"}, bus.start_ready,  1);
    check({tag, "_done_valid"},  bus.done_valid,   0);
    check({tag, "_diff"},        bus.diff,         0);
    check({tag, "_borrow"},      bus.borrow,       0);
    check({tag, "_overflow"},    bus.overflow,     0);
    check({tag, "_zero"},        bus.zero,         0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] ra, rb;
    int mode;
    corners[0] = 32'h0000_0000;
    corners[1] = 32'h0000_0001;
    corners[2] = 32'h7FFF_FFFF;
    corners[3] = 32'h8000_0000;
    corners[4] = 32'hFFFF_FFFF;

    reset = 1'b1;
    bus.start_valid = 1'b0;
    bus.done_ready  = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("por");
    reset = 1'b0;

    run_op(32'd10, 32'd3, 0);
    run_op(32'd0, 32'd1, 2);
    run_op(32'h8000_0000, 32'd1, 0);
    run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 5);
    run_op(32'h1234_5678, 32'h1234_5678, 1);
    run_op(32'hDEAD_BEEF, 32'h0000_0001, 0);

    // Reset in the middle of RUN discards the operation
    accept($urandom, $urandom);
    repeat (4) @(posedge clk);
    #1;
    check("mid_run_state", state_dbg, RUN);
    check("mid_run_count", count_dbg, 4);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_values("run_reset");
    run_op(32'd5, 32'd9, 0);

    // Reset while the result is being presented
    accept(32'hFFFF_0000, 32'h0000_FFFF);
    repeat (8) @(posedge clk);
    #1;
    check("done_before_reset", bus.done_valid, 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_reset_values("done_reset");

    for (int n = 0; n < 25; n++) begin
      mode = $urandom_range(0, 3);
      ra = $urandom;
      rb = $urandom;
      case (mode)
        1: rb = ra;
        2: rb = ra + 32'd1;
        3: begin
          ra = corners[$urandom_range(0, 4)];
          rb = corners[$urandom_range(0, 4)];
        end
        default: ;
      endcase
      run_op(ra, rb, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
